// File: rtl/riscv_mem_pkg.sv
// Shared memory-side definitions for the data cache and its block responder.
// Holds the responder state encoding and the default block geometry.
package riscv_mem_pkg;

    localparam int MEM_ADDR_WIDTH  = 10;
    localparam int MEM_BLOCK_WIDTH = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    // Counter width able to hold the larger of the two latency reload values.
    function automatic int cnt_bits(input int lat_a, input int lat_b);
        int m;
        m = (lat_a > lat_b) ? lat_a : lat_b;
        if (m < 2) begin
            return 1;
        end
        return $clog2(m);
    endfunction

endpackage

// File: rtl/riscv_block_ram.sv
// Synchronous single-port block array with a registered, enable-gated read port.
// Contents are never cleared; only the read register is reset.
module riscv_block_ram
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = MEM_ADDR_WIDTH,
    parameter int BLOCK_WIDTH = MEM_BLOCK_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic                   re,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [BLOCK_WIDTH-1:0] wdata,
    output logic [BLOCK_WIDTH-1:0] rdata
);

    logic [BLOCK_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Block write; storage survives reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register holds its value until the next enabled read.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/riscv_dmem_responder.sv
// Memory-side responder for data cache block refill and write-back.
// Accepts held requests, counts out the latency, then pulses mem_ready.
module riscv_dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_WIDTH    = MEM_ADDR_WIDTH,
    parameter int BLOCK_WIDTH   = MEM_BLOCK_WIDTH,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_rden,
    input  logic                   mem_wren,
    input  logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [BLOCK_WIDTH-1:0] mem_wdata,
    output logic                   mem_ready,
    output logic [BLOCK_WIDTH-1:0] mem_rdata,
    output logic                   mem_busy
);

    localparam int CNT_W = cnt_bits(READ_LATENCY, WRITE_LATENCY);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    mem_state_t state;
    mem_state_t state_next;

    logic [CNT_W-1:0]       cnt;
    logic                   cap_write;
    logic [ADDR_WIDTH-1:0]  cap_addr;
    logic [BLOCK_WIDTH-1:0] cap_wdata;

    logic                   accept;
    logic                   acc_one;
    logic                   held;
    logic                   to_done;
    logic                   op_write;
    logic                   ram_we;
    logic                   ram_re;
    logic [ADDR_WIDTH-1:0]  ram_addr;
    logic [BLOCK_WIDTH-1:0] ram_wdata;

    // Write wins when both requests are raised together.
    assign acc_one = mem_wren ? (WRITE_LATENCY == 1) : (READ_LATENCY == 1);

    // Request line belonging to the operation in flight.
    assign held = cap_write ? mem_wren : mem_rden;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: accept, count down, abort on dropped request.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_wren || mem_rden) begin
                    accept     = 1'b1;
                    state_next = acc_one ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (!held) begin
                    state_next = IDLE;
                end else if (cnt == CNT_ONE) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Storage access happens on the edge that enters DONE. A one-cycle
    // op enters DONE straight from IDLE, so it uses the live inputs.
    assign to_done   = (state != DONE) && (state_next == DONE);
    assign op_write  = (state == IDLE) ? mem_wren : cap_write;
    assign ram_addr  = (state == IDLE) ? mem_addr : cap_addr;
    assign ram_wdata = (state == IDLE) ? mem_wdata : cap_wdata;
    assign ram_we    = rst && to_done && op_write;
    assign ram_re    = rst && to_done && !op_write;

    // Capture registers and latency counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt       <= '0;
            cap_write <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else if (accept) begin
            cnt       <= mem_wren ? WR_LOAD : RD_LOAD;
            cap_write <= mem_wren;
            cap_addr  <= mem_addr;
            cap_wdata <= mem_wdata;
        end else if (state == BUSY && cnt != CNT_ZERO) begin
            cnt <= cnt - CNT_ONE;
        end
    end

    // Outputs decode straight from the state register.
    always_comb begin
        mem_ready = (state == DONE);
        mem_busy  = (state != IDLE);
    end

    riscv_block_ram #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .BLOCK_WIDTH (BLOCK_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (mem_rdata)
    );

endmodule
